game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clk cycles per timer second (≥2).
REQ-002 Parameter CELLS, default 64, board cell count (`MAP_HEIGHT * `MAP_WIDTH).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start_button_i  in  1  debounced one-cycle start/restart pulse.
REQ-006 mid_button_i  in  1  debounced one-cycle reveal-click pulse from the input block.
REQ-007 gen_done_i  in  1  one-cycle pulse from the map generator; map_i/mine_mask_i are valid from that cycle on.
REQ-008 mine_mask_i  in  CELLS  1 = cell holds a mine.
REQ-009 map_shown_i  in  CELLS  revealed-cell vector from sweep.
REQ-010 play_end_fail_i  in  1  sweep flag: a mine was revealed.
REQ-011 screen_state_o  out  3  `GAME_START / `GAME_PLAY / `GAME_WIN / `GAME_FAIL, fed to sweep and display.
REQ-012 gen_req_o  out  1  one-cycle request to the map generator.
REQ-013 click_o  out  1  gated reveal pulse to sweep mid_button_i.
REQ-014 time_o  out  10  elapsed play seconds, 0..999.

Function
REQ-015 Internal FSM states are START, GEN, PLAY, WIN and FAIL; screen_state_o is registered and shows `GAME_START in both START and GEN.
REQ-016 START: start_button_i moves to GEN, with gen_req_o high for exactly the next cycle.
REQ-017 GEN: holds until gen_done_i, then moves to PLAY on the following edge; start_button_i and mid_button_i are ignored.
REQ-018 PLAY: click_o equals mid_button_i delayed one cycle; clicks outside PLAY never reach click_o.
REQ-019 PLAY: play_end_fail_i high moves to FAIL next edge.
REQ-020 PLAY: win is (map_shown_i | mine_mask_i) all ones, with mine_mask_i not all ones; win moves to WIN next edge.
REQ-021 Fail and win in the same cycle go to FAIL (fail priority).
REQ-022 PLAY: start_button_i aborts to START; a click in the same cycle is dropped.
REQ-023 PLAY: start_button_i ranks below fail and win, which are taken instead.
REQ-024 WIN/FAIL: outputs hold; start_button_i moves to START; all other inputs are ignored.
REQ-025 A click pulse already launched on click_o completes even if the state leaves PLAY that cycle.
REQ-026 gen_req_o never asserts outside the START→GEN transition.

Reset
REQ-027 Synchronous rst forces state START, screen_state_o=`GAME_START, gen_req_o=0, click_o=0, time_o=0, tick divider=0.
REQ-028 rst takes precedence over every input in the same cycle.
REQ-029 rst mid-GEN drops the pending request and ignores a later stray gen_done_i while in START.

Configuration
REQ-030 With macro GAME_TIMER_EN defined, a divider counts 0..TICK_DIV-1 only in PLAY.
REQ-031 With GAME_TIMER_EN, each divider wrap increments time_o, saturating at 999.
REQ-032 With GAME_TIMER_EN, time_o and the divider clear on entry to GEN; time_o freezes in WIN/FAIL.
REQ-033 Without GAME_TIMER_EN, time_o is tied to 0 and no divider logic exists.

Verification
REQ-034 Reset, then start_button_i pulse → gen_req_o=1 exactly one cycle later; screen_state_o stays `GAME_START until gen_done_i, then `GAME_PLAY next edge.
REQ-035 In PLAY, mid_button_i pulse at cycle N → click_o=1 at cycle N+1 only; same pulse in GEN or FAIL → click_o stays 0.
REQ-036 mine_mask_i=64'h1, map_shown_i driven to 64'hFFFF_FFFF_FFFF_FFFE → `GAME_WIN next edge; the same map plus play_end_fail_i=1 → `GAME_FAIL.
REQ-037 TICK_DIV=4 with GAME_TIMER_EN: 40 PLAY cycles → time_o=10; hold in WIN → time_o stays 10; without the macro → time_o=0 throughout.
REQ-038 start_button_i and mid_button_i together in PLAY → START, click_o=0; rst asserted in GEN → START, and a following gen_done_i pulse → no state change.

Source files
------------

// File: rtl/game_ctrl_if.sv
// Game controller bus: buttons, generator handshake, sweep status and controller outputs.
// Also provides default screen-state codes when the codebase has not defined them.
`ifndef GAME_START
`define GAME_START 3'd0
`endif
`ifndef GAME_PLAY
`define GAME_PLAY 3'd1
`endif
`ifndef GAME_WIN
`define GAME_WIN 3'd2
`endif
`ifndef GAME_FAIL
`define GAME_FAIL 3'd3
`endif

interface game_ctrl_if #(
    parameter int unsigned CELLS = 64
);
    logic             start_button_i;
    logic             mid_button_i;
    logic             gen_done_i;
    logic [CELLS-1:0] mine_mask_i;
    logic [CELLS-1:0] map_shown_i;
    logic             play_end_fail_i;
    logic [2:0]       screen_state_o;
    logic             gen_req_o;
    logic             click_o;
    logic [9:0]       time_o;

    modport master (
        input  start_button_i, mid_button_i, gen_done_i,
        input  mine_mask_i, map_shown_i, play_end_fail_i,
        output screen_state_o, gen_req_o, click_o, time_o
    );

    modport slave (
        output start_button_i, mid_button_i, gen_done_i,
        output mine_mask_i, map_shown_i, play_end_fail_i,
        input  screen_state_o, gen_req_o, click_o, time_o
    );
endinterface

// File: rtl/game_ctrl.sv
// Minesweeper game controller: start/generate/play/win/fail sequencing and click gating.
// Optional play timer enabled by defining GAME_TIMER_EN.
module game_ctrl #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned CELLS    = 64
) (
    input  logic          clk,
    input  logic          rst,
    game_ctrl_if.master   bus
);

    if (TICK_DIV < 2) begin : g_tick_div_check
        $error("game_ctrl: TICK_DIV must be at least 2");
    end

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_GEN   = 3'd1,
        S_PLAY  = 3'd2,
        S_WIN   = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t           state_q;
    logic [2:0]       screen_q;
    logic             gen_req_q;
    logic             click_q;
    logic [CELLS-1:0] covered_c;
    logic             win_c;
    logic             abort_c;
    logic             gen_entry_c;

    // Board is won once every safe cell is revealed; an all-mine board can never be won.
    assign covered_c   = bus.map_shown_i | bus.mine_mask_i;
    assign win_c       = (&covered_c) && !(&bus.mine_mask_i);
    assign abort_c     = bus.start_button_i && !bus.play_end_fail_i && !win_c;
    assign gen_entry_c = (state_q == S_START) && bus.start_button_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_START;
            screen_q  <= `GAME_START;
            gen_req_q <= 1'b0;
            click_q   <= 1'b0;
        end else begin
            gen_req_q <= 1'b0;
            click_q   <= 1'b0;
            case (state_q)
                S_START: begin
                    if (bus.start_button_i) begin
                        state_q   <= S_GEN;
                        gen_req_q <= 1'b1;
                    end
                end
                S_GEN: begin
                    if (bus.gen_done_i) begin
                        state_q  <= S_PLAY;
                        screen_q <= `GAME_PLAY;
                    end
                end
                S_PLAY: begin
                    // An abort drops a coincident click; fail/win outrank the abort.
                    click_q <= bus.mid_button_i && !abort_c;
                    if (bus.play_end_fail_i) begin
                        state_q  <= S_FAIL;
                        screen_q <= `GAME_FAIL;
                    end else if (win_c) begin
                        state_q  <= S_WIN;
                        screen_q <= `GAME_WIN;
                    end else if (bus.start_button_i) begin
                        state_q  <= S_START;
                        screen_q <= `GAME_START;
                    end
                end
                S_WIN, S_FAIL: begin
                    if (bus.start_button_i) begin
                        state_q  <= S_START;
                        screen_q <= `GAME_START;
                    end
                end
                default: begin
                    state_q  <= S_START;
                    screen_q <= `GAME_START;
                end
            endcase
        end
    end

    assign bus.screen_state_o = screen_q;
    assign bus.gen_req_o      = gen_req_q;
    assign bus.click_o        = click_q;

`ifdef GAME_TIMER_EN
    localparam int unsigned DIV_W    = $clog2(TICK_DIV);
    localparam int unsigned TIME_MAX = 999;

    logic [DIV_W-1:0] div_q;
    logic [9:0]       time_q;

    // Seconds timer runs only while playing and restarts with each new board.
    always_ff @(posedge clk) begin
        if (rst || gen_entry_c) begin
            div_q  <= '0;
            time_q <= '0;
        end else if (state_q == S_PLAY) begin
            if (div_q == DIV_W'(TICK_DIV - 1)) begin
                div_q <= '0;
                if (time_q != 10'(TIME_MAX)) begin
                    time_q <= time_q + 10'd1;
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    assign bus.time_o = time_q;
`else
    logic unused_gen_entry;
    assign unused_gen_entry = gen_entry_c;
    assign bus.time_o       = 10'd0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Randomised scoreboard bench for game_ctrl against a rule-level reference model.
// Timer expectations follow GAME_TIMER_EN when it is defined for the build.
`ifndef GAME_START
`define GAME_START 3'd0
`endif
`ifndef GAME_PLAY
`define GAME_PLAY 3'd1
`endif
`ifndef GAME_WIN
`define GAME_WIN 3'd2
`endif
`ifndef GAME_FAIL
`define GAME_FAIL 3'd3
`endif

module tb_game_ctrl;

    localparam int unsigned TICK  = 4;
    localparam int unsigned NCELL = 64;

    logic clk;
    logic rst;

    game_ctrl_if #(.CELLS(NCELL)) bus ();

    game_ctrl #(.TICK_DIV(TICK), .CELLS(NCELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {M_START, M_GEN, M_PLAY, M_WIN, M_FAIL} mode_t;

    typedef struct {
        logic [2:0] screen;
        logic       gen_req;
        logic       click;
        logic [9:0] tm;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    mode_t       m_mode;
    int          m_play;
    int          cyc_n;
    int          n_checks;
    int          n_pass;
    logic [63:0] cur_mask;
    logic [63:0] cur_shown;
    bit          stim_done;

    function automatic logic [2:0] screen_of(input mode_t m);
        case (m)
            M_PLAY:  return `GAME_PLAY;
            M_WIN:   return `GAME_WIN;
            M_FAIL:  return `GAME_FAIL;
            default: return `GAME_START;
        endcase
    endfunction

    function automatic logic [9:0] time_of(input int play_cycles);
`ifdef GAME_TIMER_EN
        int secs;
        secs = play_cycles / TICK;
        return 10'((secs > 999) ? 999 : secs);
`else
        return 10'(play_cycles * 0);
`endif
    endfunction

    // Apply one cycle of inputs, advance the model by the game rules, queue the outcome.
    task automatic step(input bit r, input bit st, input bit mid, input bit gd,
                        input bit fail, input logic [63:0] mask, input logic [63:0] shown);
        exp_t e;
        bit   won;
        rst                 = r;
        bus.start_button_i  = st;
        bus.mid_button_i    = mid;
        bus.gen_done_i      = gd;
        bus.play_end_fail_i = fail;
        bus.mine_mask_i     = mask;
        bus.map_shown_i     = shown;
        won = ($countones(mask | shown) == NCELL) && ($countones(mask) != NCELL);
        e.gen_req = 1'b0;
        e.click   = 1'b0;
        if (r) begin
            m_mode = M_START;
            m_play = 0;
        end else begin
            case (m_mode)
                M_START: if (st) begin
                    m_mode    = M_GEN;
                    m_play    = 0;
                    e.gen_req = 1'b1;
                end
                M_GEN: if (gd) m_mode = M_PLAY;
                M_PLAY: begin
                    m_play  = m_play + 1;
                    e.click = mid && !(st && !fail && !won);
                    if (fail)     m_mode = M_FAIL;
                    else if (won) m_mode = M_WIN;
                    else if (st)  m_mode = M_START;
                end
                default: if (st) m_mode = M_START;
            endcase
        end
        e.screen = screen_of(m_mode);
        e.tm     = time_of(m_play);
        e.cyc    = cyc_n;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc_n = cyc_n + 1;
    endtask

    task automatic pulse(input bit st, input bit mid, input bit gd, input bit fail);
        step(1'b0, st, mid, gd, fail, cur_mask, cur_shown);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input int cyc, input logic [9:0] act,
                         input logic [9:0] req);
        n_checks = n_checks + 1;
        if (act === req) n_pass = n_pass + 1;
        else $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    endtask

    // Monitor: compare the registered outputs mid-cycle against the oldest queued outcome.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("screen_state", e.cyc, 10'(bus.screen_state_o), 10'(e.screen));
                check("gen_req", e.cyc, 10'(bus.gen_req_o), 10'(e.gen_req));
                check("click", e.cyc, 10'(bus.click_o), 10'(e.click));
                check("time", e.cyc, bus.time_o, e.tm);
            end
        end
    end

    initial begin
        logic [63:0] rmask;
        logic [63:0] rshown;
        int          sel;
        n_checks  = 0;
        n_pass    = 0;
        cyc_n     = 0;
        m_mode    = M_START;
        m_play    = 0;
        stim_done = 1'b0;
        cur_mask  = 64'h1;
        cur_shown = 64'h0;

        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, cur_mask, cur_shown);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cur_mask, cur_shown);
        idle(2);

        // Start, wait in generation, then play with a click and 40 timed cycles.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        idle(39);

        // Win on the last safe cell, then hold with ignored inputs.
        cur_shown = 64'hFFFF_FFFF_FFFF_FFFE;
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        cur_shown = 64'h0;
        pulse(1'b0, 1'b1, 1'b1, 1'b1);
        idle(4);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);

        // Click during generation is gated; fail outranks a coincident win.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        cur_shown = 64'hFFFF_FFFF_FFFF_FFFE;
        pulse(1'b1, 1'b1, 1'b0, 1'b1);
        cur_shown = 64'h0;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);

        // Abort with a simultaneous click; all-mine board never counts as a win.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        cur_mask  = '1;
        cur_shown = '1;
        idle(3);
        cur_mask  = 64'h1;
        cur_shown = 64'h0;
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Reset during generation, then a stray done pulse.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cur_mask, cur_shown);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Long game to push the timer to saturation, then freeze on fail.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        idle(4010);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);

        // Random traffic across all states.
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       rmask = 64'h1;
                1:       rmask = {$urandom(), $urandom()};
                2:       rmask = '1;
                default: rmask = 64'h0;
            endcase
            sel = int'($urandom_range(0, 19));
            if (sel < 2)       rshown = ~rmask;
            else if (sel == 2) rshown = '1;
            else               rshown = {$urandom(), $urandom()} & 64'h00FF_FFFF_FFFF_FFFF;
            step($urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 15) == 0, rmask, rshown);
        end
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        repeat (3) @(posedge clk);
        check("queue_drained", cyc_n, 10'(exp_q.size()), 10'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: stimulus did not complete, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
